// File: rtl/prim_stack_unit_pkg.sv
// Shared op codes and the need/delta tables for the Prim stack engine.
// The core decoder and the testbench both import this package.
package prim_stack_unit_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSH  = 4'd1;
  localparam logic [3:0] OP_DROP  = 4'd2;
  localparam logic [3:0] OP_REPL  = 4'd3;
  localparam logic [3:0] OP_BINOP = 4'd4;
  localparam logic [3:0] OP_SWAP  = 4'd5;
  localparam logic [3:0] OP_DUP   = 4'd6;
  localparam logic [3:0] OP_OVER  = 4'd7;
  localparam logic [3:0] OP_NIP   = 4'd8;
  localparam logic [3:0] OP_ROT   = 4'd9;
  localparam logic [3:0] OP_NROT  = 4'd10;

  typedef enum logic [1:0] {
    DELTA_NONE = 2'd0,
    DELTA_INC  = 2'd1,
    DELTA_DEC  = 2'd2
  } delta_e;

  // Minimum number of live entries an op needs before it may execute.
  function automatic logic [1:0] opNeed(input logic [3:0] op);
    logic [1:0] need;
    need = 2'd0;
    case (op)
      OP_DROP, OP_REPL, OP_DUP:             need = 2'd1;
      OP_BINOP, OP_SWAP, OP_OVER, OP_NIP:   need = 2'd2;
      OP_ROT, OP_NROT:                      need = 2'd3;
      default:                              need = 2'd0;
    endcase
    return need;
  endfunction

  function automatic delta_e opDelta(input logic [3:0] op);
    delta_e delta;
    delta = DELTA_NONE;
    case (op)
      OP_PUSH, OP_DUP, OP_OVER:             delta = DELTA_INC;
      OP_DROP, OP_BINOP, OP_NIP:            delta = DELTA_DEC;
      default:                              delta = DELTA_NONE;
    endcase
    return delta;
  endfunction

endpackage

// File: rtl/prim_stack_unit_if.sv
// Op/data request and stack-state view of one stack engine.
interface prim_stack_unit_if #(
  parameter int WIDTH = 16,
  parameter int DSS   = 4
);

  logic             i_en;
  logic [3:0]       i_op;
  logic [WIDTH-1:0] i_dat;
  logic             i_clr_err;
  logic [WIDTH-1:0] o_t;
  logic [WIDTH-1:0] o_n;
  logic [WIDTH-1:0] o_third;
  logic [DSS+1:0]   o_depth;
  logic             o_empty;
  logic             o_full;
  logic             o_ovf;
  logic             o_unf;

  modport master (
    output i_en, i_op, i_dat, i_clr_err,
    input  o_t, o_n, o_third, o_depth, o_empty, o_full, o_ovf, o_unf
  );

  modport slave (
    input  i_en, i_op, i_dat, i_clr_err,
    output o_t, o_n, o_third, o_depth, o_empty, o_full, o_ovf, o_unf
  );

endinterface

// File: rtl/prim_stack_unit_ram.sv
// Spill RAM holding stack entries below N: synchronous write, asynchronous read.
module prim_stack_ram #(
  parameter int WIDTH = 16,
  parameter int DSS   = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [DSS-1:0]   i_waddr,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic [DSS-1:0]   i_raddr,
  output logic [WIDTH-1:0] o_rdat
);

  logic [WIDTH-1:0] mem_q [2**DSS];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdat;
  end

  assign o_rdat = mem_q[i_raddr];

endmodule

// File: rtl/prim_stack_unit.sv
// Stack engine: T/N in registers, deeper entries in the spill RAM, one op per clock
// with depth tracking and sticky overflow/underflow flags.
module prim_stack_unit
  import prim_stack_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DSS   = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  prim_stack_unit_if.slave   bus
);

  localparam int             MaxDepth  = 2**DSS + 2;
  localparam logic [DSS+1:0] MAX_DEPTH = (DSS+2)'(MaxDepth);
  localparam logic [DSS+1:0] DEPTH_ONE = (DSS+2)'(1);
  localparam logic [DSS+1:0] DEPTH_TWO = (DSS+2)'(2);

  logic [WIDTH-1:0] t_q, t_d, n_q, n_d;
  logic [DSS+1:0]   depth_q, depth_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;

  logic             ramWe;
  logic [DSS-1:0]   ramWaddr, ramRaddr;
  logic [WIDTH-1:0] ramWdat, third;
  logic [WIDTH-1:0] pushVal;
  logic             isUnf, isOvf, doOp;
  delta_e           delta;

  // Spill addresses wrap modulo the RAM size, which matches depth-2/depth-3 whenever valid.
  assign ramRaddr = depth_q[DSS-1:0] - DSS'(3);

  prim_stack_ram #(.WIDTH(WIDTH), .DSS(DSS)) u_ram (
    .i_clk   (i_clk),
    .i_we    (ramWe),
    .i_waddr (ramWaddr),
    .i_wdat  (ramWdat),
    .i_raddr (ramRaddr),
    .o_rdat  (third)
  );

  assign delta   = opDelta(bus.i_op);
  assign isUnf   = bus.i_en && (depth_q < {{DSS{1'b0}}, opNeed(bus.i_op)});
  assign isOvf   = bus.i_en && !isUnf && (delta == DELTA_INC) && (depth_q == MAX_DEPTH);
  assign doOp    = bus.i_en && !isUnf && !isOvf;
  assign pushVal = (bus.i_op == OP_DUP)  ? t_q :
                   (bus.i_op == OP_OVER) ? n_q : bus.i_dat;

  always_comb begin
    t_d      = t_q;
    n_d      = n_q;
    depth_d  = depth_q;
    ramWe    = 1'b0;
    ramWaddr = depth_q[DSS-1:0] - DSS'(2);
    ramWdat  = n_q;
    if (doOp) begin
      case (bus.i_op)
        OP_PUSH, OP_DUP, OP_OVER: begin
          t_d   = pushVal;
          n_d   = t_q;
          ramWe = (depth_q >= DEPTH_TWO);
        end
        OP_DROP: begin
          t_d = n_q;
          n_d = third;
        end
        OP_REPL:  t_d = bus.i_dat;
        OP_BINOP: begin
          t_d = bus.i_dat;
          n_d = third;
        end
        OP_SWAP: begin
          t_d = n_q;
          n_d = t_q;
        end
        OP_NIP:   n_d = third;
        OP_ROT: begin
          t_d      = third;
          n_d      = t_q;
          ramWe    = 1'b1;
          ramWaddr = ramRaddr;
          ramWdat  = n_q;
        end
        OP_NROT: begin
          t_d      = n_q;
          n_d      = third;
          ramWe    = 1'b1;
          ramWaddr = ramRaddr;
          ramWdat  = t_q;
        end
        default: ;
      endcase
      if (delta == DELTA_INC)      depth_d = depth_q + DEPTH_ONE;
      else if (delta == DELTA_DEC) depth_d = depth_q - DEPTH_ONE;
    end
  end

  // A fault in the same cycle as a clear request leaves the flag set.
  always_comb begin
    ovf_d = bus.i_clr_err ? 1'b0 : ovf_q;
    unf_d = bus.i_clr_err ? 1'b0 : unf_q;
    if (isOvf) ovf_d = 1'b1;
    if (isUnf) unf_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      t_q     <= '0;
      n_q     <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      t_q     <= t_d;
      n_q     <= n_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.o_t     = t_q;
  assign bus.o_n     = n_q;
  assign bus.o_third = third;
  assign bus.o_depth = depth_q;
  assign bus.o_empty = (depth_q == '0);
  assign bus.o_full  = (depth_q == MAX_DEPTH);
  assign bus.o_ovf   = ovf_q;
  assign bus.o_unf   = unf_q;

endmodule

// File: tb/tb_prim_stack_unit.sv
// Directed self-checking bench for prim_stack_unit with DSS=2 (six-entry stack).
module tb_prim_stack_unit;
  import prim_stack_unit_pkg::*;

  localparam int WIDTH = 16;
  localparam int DSS   = 2;

  logic clk;
  logic reset;
  int   checkCount;
  int   failCount;

  prim_stack_unit_if #(.WIDTH(WIDTH), .DSS(DSS)) bus ();

  prim_stack_unit #(.WIDTH(WIDTH), .DSS(DSS)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs on the falling edge; outputs settle #1 after the rising edge.
  task automatic applyStimulus(input logic en, input logic [3:0] op,
                               input logic [15:0] dat, input logic clr, input logic rst);
    @(negedge clk);
    bus.i_en      = en;
    bus.i_op      = op;
    bus.i_dat     = dat;
    bus.i_clr_err = clr;
    reset         = rst;
    @(posedge clk);
    #1;
    bus.i_en      = 1'b0;
    bus.i_clr_err = 1'b0;
    reset         = 1'b0;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, OP_NOP, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic doOp(input logic [3:0] op, input logic [15:0] dat);
    applyStimulus(1'b1, op, dat, 1'b0, 1'b0);
  endtask

  initial begin
    checkCount    = 0;
    failCount     = 0;
    reset         = 1'b1;
    bus.i_en      = 1'b0;
    bus.i_op      = OP_NOP;
    bus.i_dat     = '0;
    bus.i_clr_err = 1'b0;
    doReset();
    doReset();
    checkOutput("rst_t", bus.o_t, 0);
    checkOutput("rst_n", bus.o_n, 0);
    checkOutput("rst_depth", bus.o_depth, 0);
    checkOutput("rst_empty", bus.o_empty, 1);
    checkOutput("rst_ovf", bus.o_ovf, 0);
    checkOutput("rst_unf", bus.o_unf, 0);

    for (int i = 1; i <= 6; i++) doOp(OP_PUSH, 16'(i));
    checkOutput("fill_depth", bus.o_depth, 6);
    checkOutput("fill_full", bus.o_full, 1);
    checkOutput("fill_t", bus.o_t, 6);
    checkOutput("fill_n", bus.o_n, 5);
    checkOutput("fill_third", bus.o_third, 4);
    doOp(OP_PUSH, 16'd7);
    checkOutput("ovf_flag", bus.o_ovf, 1);
    checkOutput("ovf_t", bus.o_t, 6);
    checkOutput("ovf_depth", bus.o_depth, 6);

    for (int i = 5; i >= 1; i--) begin
      doOp(OP_DROP, 16'd0);
      checkOutput("drop_t", bus.o_t, i);
    end
    doOp(OP_DROP, 16'd0);
    checkOutput("drop_depth", bus.o_depth, 0);
    checkOutput("drop_empty", bus.o_empty, 1);
    checkOutput("drop_unf_pre", bus.o_unf, 0);
    doOp(OP_DROP, 16'd0);
    checkOutput("drop_unf", bus.o_unf, 1);
    checkOutput("drop_unf_depth", bus.o_depth, 0);

    doReset();
    doOp(OP_PUSH, 16'd1);
    doOp(OP_PUSH, 16'd2);
    doOp(OP_PUSH, 16'd3);
    doOp(OP_ROT, 16'd0);
    checkOutput("rot_t", bus.o_t, 1);
    checkOutput("rot_n", bus.o_n, 3);
    checkOutput("rot_third", bus.o_third, 2);
    doOp(OP_NROT, 16'd0);
    checkOutput("nrot_t", bus.o_t, 3);
    checkOutput("nrot_n", bus.o_n, 2);
    checkOutput("nrot_third", bus.o_third, 1);
    doOp(4'd12, 16'd55);
    checkOutput("rsvd_t", bus.o_t, 3);
    checkOutput("rsvd_depth", bus.o_depth, 3);
    checkOutput("rsvd_unf", bus.o_unf, 0);
    doOp(OP_REPL, 16'd44);
    checkOutput("repl_t", bus.o_t, 44);
    checkOutput("repl_n", bus.o_n, 2);

    doReset();
    doOp(OP_PUSH, 16'd10);
    doOp(OP_PUSH, 16'd20);
    doOp(OP_BINOP, 16'd30);
    checkOutput("binop_depth", bus.o_depth, 1);
    checkOutput("binop_t", bus.o_t, 30);
    doOp(OP_SWAP, 16'd0);
    checkOutput("swap_unf", bus.o_unf, 1);
    checkOutput("swap_t", bus.o_t, 30);
    checkOutput("swap_depth", bus.o_depth, 1);

    doReset();
    doOp(OP_PUSH, 16'd7);
    doOp(OP_PUSH, 16'd8);
    doOp(OP_OVER, 16'd0);
    checkOutput("over_t", bus.o_t, 7);
    checkOutput("over_n", bus.o_n, 8);
    checkOutput("over_third", bus.o_third, 7);
    checkOutput("over_depth", bus.o_depth, 3);
    doOp(OP_DUP, 16'd0);
    checkOutput("dup_t", bus.o_t, 7);
    checkOutput("dup_depth", bus.o_depth, 4);
    doOp(OP_NIP, 16'd0);
    checkOutput("nip_t", bus.o_t, 7);
    checkOutput("nip_n", bus.o_n, 8);
    checkOutput("nip_depth", bus.o_depth, 3);

    doReset();
    doOp(OP_ROT, 16'd0);
    checkOutput("err_set", bus.o_unf, 1);
    applyStimulus(1'b1, OP_ROT, 16'd0, 1'b1, 1'b0);
    checkOutput("err_clr_vs_set", bus.o_unf, 1);
    applyStimulus(1'b0, OP_NOP, 16'd0, 1'b1, 1'b0);
    checkOutput("err_clr", bus.o_unf, 0);
    doOp(OP_PUSH, 16'd5);
    checkOutput("pre_rst_depth", bus.o_depth, 1);
    applyStimulus(1'b1, OP_PUSH, 16'd99, 1'b0, 1'b1);
    checkOutput("midrst_depth", bus.o_depth, 0);
    checkOutput("midrst_t", bus.o_t, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
